// File: rtl/max_pool_1_mul_pipe.sv
// max_pool_1_mul_pipe
//   Pipelined multiply-add for the max-pool address datapath.
//   Computes din0*din1 + din2, or accumulates din0*din1 into an internal
//   register, and flags results that do not fit in DOUT_WIDTH.
// Ports:
//   ap_clk, ap_rst_n      clock, async active-low reset
//   ce                    clock enable; 0 freezes every register
//   in_valid              sample valid (qualified by ce)
//   din0, din1, din2      multiplicand, multiplier, addend
//   acc_en, acc_clr       accumulate select / restart accumulator from 0
//   out_valid, dout, ovf  result valid, truncated result, overflow flag
module max_pool_1_mul_pipe #(
  parameter int DIN0_WIDTH = 11,
  parameter int DIN1_WIDTH = 5,
  parameter int DOUT_WIDTH = 16,
  parameter int NUM_STAGE  = 3,
  parameter int SIGNED     = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic [DOUT_WIDTH-1:0] din2,
  input  logic                  acc_en,
  input  logic                  acc_clr,
  output logic                  out_valid,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  ovf
);
  localparam int P  = DIN0_WIDTH + DIN1_WIDTH;
  localparam int RW = ((P > DOUT_WIDTH) ? P : DOUT_WIDTH) + 1;

  typedef struct packed {
    logic                  v;
    logic                  acc_en;
    logic                  acc_clr;
    logic [P-1:0]          prod;
    logic [DOUT_WIDTH-1:0] c;
  } stage_t;

  logic [P-1:0] a_ext, b_ext;
  stage_t       s_in, s_fin;

  logic [DOUT_WIDTH-1:0] acc, base, res;
  logic [RW-1:0]         prod_w, base_w, res_w, r;

  // Operands extended to P bits: the P-bit wrapped product of the extended
  // operands is exact in both signed and unsigned modes.
  generate
    if (SIGNED != 0) begin : g_sext
      assign a_ext  = {{DIN1_WIDTH{din0[DIN0_WIDTH-1]}}, din0};
      assign b_ext  = {{DIN0_WIDTH{din1[DIN1_WIDTH-1]}}, din1};
      assign prod_w = {{(RW-P){s_fin.prod[P-1]}}, s_fin.prod};
      assign base_w = {{(RW-DOUT_WIDTH){base[DOUT_WIDTH-1]}}, base};
      assign res_w  = {{(RW-DOUT_WIDTH){res[DOUT_WIDTH-1]}}, res};
    end else begin : g_zext
      assign a_ext  = {{DIN1_WIDTH{1'b0}}, din0};
      assign b_ext  = {{DIN0_WIDTH{1'b0}}, din1};
      assign prod_w = {{(RW-P){1'b0}}, s_fin.prod};
      assign base_w = {{(RW-DOUT_WIDTH){1'b0}}, base};
      assign res_w  = {{(RW-DOUT_WIDTH){1'b0}}, res};
    end
  endgenerate

  // The product is formed up front; the remaining stages only delay it, which
  // is bit-exact with any distribution of the multiply across stages.
  always_comb begin
    s_in.v       = in_valid;
    s_in.acc_en  = acc_en;
    s_in.acc_clr = acc_clr;
    s_in.prod    = a_ext * b_ext;
    s_in.c       = din2;
  end

  generate
    if (NUM_STAGE == 1) begin : g_nopipe
      assign s_fin = s_in;
    end else begin : g_pipe
      stage_t pipe_q [NUM_STAGE-1];
      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          for (int i = 0; i < NUM_STAGE-1; i++) pipe_q[i] <= '0;
        end else if (ce) begin
          pipe_q[0] <= s_in;
          for (int i = 1; i < NUM_STAGE-1; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign s_fin = pipe_q[NUM_STAGE-2];
    end
  endgenerate

  // Final stage: acc is read here and written on the same edge, so
  // back-to-back accumulate samples chain without a gap.
  always_comb begin
    base = s_fin.acc_en ? (s_fin.acc_clr ? '0 : acc) : s_fin.c;
    r    = prod_w + base_w;
    res  = r[DOUT_WIDTH-1:0];
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid <= 1'b0;
      dout      <= '0;
      ovf       <= 1'b0;
      acc       <= '0;
    end else if (ce) begin
      out_valid <= s_fin.v;
      if (s_fin.v) begin
        dout <= res;
        ovf  <= (r != res_w);
        if (s_fin.acc_en) acc <= res;
      end
    end
  end

endmodule

// File: tb/tb_max_pool_1_mul_pipe.sv
// Bench for max_pool_1_mul_pipe: four builds (unsigned/3 stages,
// signed/3 stages, unsigned/1 stage, unsigned/5 stages) driven in parallel
// and compared every cycle against an arithmetic reference model.
module tb_max_pool_1_mul_pipe;
  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        ce, in_valid, acc_en, acc_clr;
  logic [10:0] din0;
  logic [4:0]  din1;
  logic [15:0] din2;

  logic        ov [4];
  logic [15:0] dv [4];
  logic        of [4];

  localparam int NS [4] = '{3, 3, 1, 5};
  localparam bit SG [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  always #5 ap_clk = ~ap_clk;

  max_pool_1_mul_pipe #(.NUM_STAGE(3), .SIGNED(0)) u0 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce),
    .in_valid(in_valid), .din0(din0), .din1(din1), .din2(din2), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(ov[0]), .dout(dv[0]), .ovf(of[0]));
  max_pool_1_mul_pipe #(.NUM_STAGE(3), .SIGNED(1)) u1 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce),
    .in_valid(in_valid), .din0(din0), .din1(din1), .din2(din2), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(ov[1]), .dout(dv[1]), .ovf(of[1]));
  max_pool_1_mul_pipe #(.NUM_STAGE(1), .SIGNED(0)) u2 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce),
    .in_valid(in_valid), .din0(din0), .din1(din1), .din2(din2), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(ov[2]), .dout(dv[2]), .ovf(of[2]));
  max_pool_1_mul_pipe #(.NUM_STAGE(5), .SIGNED(0)) u3 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce),
    .in_valid(in_valid), .din0(din0), .din1(din1), .din2(din2), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(ov[3]), .dout(dv[3]), .ovf(of[3]));

  typedef struct packed {
    int              k;
    logic [3:0][15:0] d;
    logic [3:0]       o;
  } smp_t;

  smp_t        q[$];
  int          rd [4];
  int          nout [4];
  logic [15:0] macc [4];
  logic        last_v [4];
  logic [15:0] last_d [4];
  logic        last_o [4];
  int          ce_cnt = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint ext(input logic [63:0] v, input int w, input bit s);
    longint x;
    x = longint'(v & ((64'd1 << w) - 64'd1));
    if (s && v[w-1]) x = x - (longint'(1) << w);
    return x;
  endfunction

  // Reference: plain integer arithmetic on the interpreted operand values.
  task automatic mdl(input int i, input logic [10:0] a, input logic [4:0] b, input logic [15:0] c,
                     input bit en, input bit clr, output logic [15:0] d, output logic o);
    longint base, r;
    base = en ? (clr ? 64'sd0 : ext(64'(macc[i]), 16, SG[i])) : ext(64'(c), 16, SG[i]);
    r = ext(64'(a), 11, SG[i]) * ext(64'(b), 5, SG[i]) + base;
    d = r[15:0];
    o = (r != ext(64'(d), 16, SG[i]));
    if (en) macc[i] = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      rd[i] = q.size(); macc[i] = '0; last_v[i] = 1'b0; last_d[i] = '0; last_o[i] = 1'b0;
    end
  endtask

  // One clock: drive inputs, step the model on the edge, compare all builds.
  task automatic cyc(input bit c_ce, input bit v, input logic [10:0] a, input logic [4:0] b,
                     input logic [15:0] c, input bit en, input bit clr);
    smp_t s;
    logic [17:0] exp;
    ce = c_ce; in_valid = v; din0 = a; din1 = b; din2 = c; acc_en = en; acc_clr = clr;
    @(posedge ap_clk);
    #1;
    if (c_ce) begin
      ce_cnt++;
      if (v) begin
        s.k = ce_cnt;
        for (int i = 0; i < 4; i++) begin
          logic [15:0] d; logic o;
          mdl(i, a, b, c, en, clr, d, o);
          s.d[i] = d; s.o[i] = o;
        end
        q.push_back(s);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (c_ce) begin
        if (rd[i] < q.size() && q[rd[i]].k + NS[i] - 1 == ce_cnt) begin
          last_v[i] = 1'b1; last_d[i] = q[rd[i]].d[i]; last_o[i] = q[rd[i]].o[i];
          rd[i]++; nout[i]++;
        end else begin
          last_v[i] = 1'b0;
        end
      end
      exp = {last_v[i], last_d[i], last_o[i]};
      chk($sformatf("cyc%0d_u%0d", ce_cnt, i), {ov[i], dv[i], of[i]}, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cyc(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    int n0;
    ap_rst_n = 1'b0; ce = 1'b0; in_valid = 1'b0; din0 = '0; din1 = '0; din2 = '0;
    acc_en = 1'b0; acc_clr = 1'b0;
    for (int i = 0; i < 4; i++) nout[i] = 0;
    model_reset();
    #2;
    for (int i = 0; i < 4; i++) chk($sformatf("reset_u%0d", i), {ov[i], dv[i], of[i]}, 18'h0);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;

    // Unsigned product, then the same product overflowing with an addend.
    cyc(1, 1, 11'd2047, 5'd31, 16'd0, 0, 0);
    chk("u2_lat1", {ov[2], dv[2], of[2]}, {1'b1, 16'd63457, 1'b0});
    cyc(1, 1, 11'd2047, 5'd31, 16'd2100, 0, 0);
    cyc(1, 1, 11'h7FD, 5'd5, 16'd0, 0, 0);
    chk("u0_lat3_a", {ov[0], dv[0], of[0]}, {1'b1, 16'd63457, 1'b0});
    cyc(1, 1, 11'h400, 5'h10, 16'd0, 0, 0);
    chk("u0_lat3_b", {ov[0], dv[0], of[0]}, {1'b1, 16'd21, 1'b1});
    cyc(1, 0, '0, '0, '0, 0, 0);
    chk("u1_sgn_a", {ov[1], dv[1], of[1]}, {1'b1, 16'hFFF1, 1'b0});
    chk("u3_lat5", {ov[3], dv[3], of[3]}, {1'b1, 16'd63457, 1'b0});
    cyc(1, 0, '0, '0, '0, 0, 0);
    chk("u1_sgn_b", {ov[1], dv[1], of[1]}, {1'b1, 16'h4000, 1'b0});
    idle(4);

    // Back-to-back accumulation with clears.
    cyc(1, 1, 11'd10, 5'd3, 16'd999, 1, 1);
    cyc(1, 1, 11'd4, 5'd2, 16'd999, 1, 0);
    cyc(1, 1, 11'd1, 5'd1, 16'd0, 1, 0);
    chk("acc_30", {ov[0], dv[0], of[0]}, {1'b1, 16'd30, 1'b0});
    cyc(1, 1, 11'd0, 5'd0, 16'd0, 1, 1);
    chk("acc_38", {ov[0], dv[0], of[0]}, {1'b1, 16'd38, 1'b0});
    cyc(1, 0, '0, '0, '0, 0, 0);
    chk("acc_39", {ov[0], dv[0], of[0]}, {1'b1, 16'd39, 1'b0});
    cyc(1, 0, '0, '0, '0, 0, 0);
    chk("acc_clr0", {ov[0], dv[0], of[0]}, {1'b1, 16'd0, 1'b0});
    idle(4);

    // Stall: 4 samples with ce low for 2 cycles in the middle.
    n0 = nout[0];
    cyc(1, 1, 11'd7, 5'd3, 16'd1, 0, 0);
    cyc(1, 1, 11'd8, 5'd3, 16'd2, 0, 0);
    cyc(0, 1, 11'd99, 5'd9, 16'd9, 0, 0);
    cyc(0, 1, 11'd98, 5'd9, 16'd9, 0, 0);
    cyc(1, 1, 11'd9, 5'd3, 16'd3, 0, 0);
    cyc(1, 1, 11'd10, 5'd3, 16'd4, 0, 0);
    idle(6);
    chk("stall_count", 18'(nout[0] - n0), 18'd4);

    // Reset with two samples in flight.
    cyc(1, 1, 11'd100, 5'd7, 16'd5, 1, 1);
    cyc(1, 1, 11'd200, 5'd7, 16'd5, 1, 0);
    ap_rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) chk($sformatf("arst_u%0d", i), {ov[i], dv[i], of[i]}, 18'h0);
    chk("arst_acc", {2'b0, u0.acc}, 18'h0);
    model_reset();
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    idle(6);

    // Randomized traffic with corner-biased operands.
    for (int j = 0; j < 10000; j++) begin
      logic [10:0] a; logic [4:0] b; logic [15:0] c;
      a = 11'($urandom); b = 5'($urandom); c = 16'($urandom);
      case ($urandom_range(0, 7))
        0: a = 11'h7FF;
        1: a = 11'h400;
        2: b = 5'h10;
        3: b = 5'h1F;
        4: c = 16'hFFFF;
        default: ;
      endcase
      cyc($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 80, a, b, c,
          $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 20);
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
